// File: rtl/err_count_serializer_if.sv
// Signal bundle for err_count_serializer.
//   master : serializer side (samples save_data/err_counts, drives the serial stream)
//   slave  : system side (drives save_data/err_counts, observes the serial stream)
// Signals:
//   save_data   - asynchronous snapshot request (rising edge)
//   err_counts  - flattened counts, channel k at [k*CNT_W +: CNT_W]
//   DATA_OUT    - registered serial data
//   frame_valid - high while DATA_OUT carries a frame bit
//   frame_start - high on the first header bit only
//   snap_lost   - one-cycle pulse when a pending snapshot is overwritten
interface err_count_serializer_if #(
    parameter int unsigned NUM_CH = 20,
    parameter int unsigned CNT_W  = 12
);
    logic                      save_data;
    logic [NUM_CH*CNT_W-1:0]   err_counts;
    logic                      DATA_OUT;
    logic                      frame_valid;
    logic                      frame_start;
    logic                      snap_lost;

    modport master (
        input  save_data,
        input  err_counts,
        output DATA_OUT,
        output frame_valid,
        output frame_start,
        output snap_lost
    );

    modport slave (
        output save_data,
        output err_counts,
        input  DATA_OUT,
        input  frame_valid,
        input  frame_start,
        input  snap_lost
    );
endinterface

// File: rtl/err_count_serializer.sv
// Error-count snapshot serializer.
// A rising edge on the asynchronous save_data input captures err_counts into a shadow
// register. Frames (header, NUM_CH counts, even-parity bit) are sent serially from a
// separate active register that is only reloaded from the shadow at frame boundaries.
// Ports:
//   data_clk - sole clock, rising edge
//   reset    - asynchronous active-low reset
//   bus      - err_count_serializer_if master modport (save_data, err_counts in;
//              DATA_OUT, frame_valid, frame_start, snap_lost out)
module err_count_serializer #(
    parameter int unsigned       NUM_CH     = 20,
    parameter int unsigned       CNT_W      = 12,
    parameter int unsigned       SYNC_W     = 8,
    parameter logic [SYNC_W-1:0] SYNC_PAT   = 8'hA5,
    parameter bit                MSB_FIRST  = 1'b0,
    parameter bit                CONTINUOUS = 1'b1
) (
    input  logic                   data_clk,
    input  logic                   reset,
    err_count_serializer_if.master bus
);
    localparam int unsigned PayW   = NUM_CH * CNT_W;
    localparam int unsigned BitMax = (SYNC_W > CNT_W) ? SYNC_W : CNT_W;
    localparam int unsigned BitCw  = (BitMax > 1) ? $clog2(BitMax) : 1;
    localparam int unsigned ChCw   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [BitCw-1:0] SyncLast = BitCw'(SYNC_W - 1);
    localparam logic [BitCw-1:0] CntLast  = BitCw'(CNT_W - 1);
    localparam logic [ChCw-1:0]  ChLast   = ChCw'(NUM_CH - 1);

    typedef enum logic [1:0] {StIdle, StSync, StData, StParity} state_e;

    // Request capture path
    logic            sync1_q, sync2_q, edge_q;
    logic [1:0]      fill_q;
    logic            armed_q, armed_d;
    logic            save_rise;

    // Snapshot storage
    logic [PayW-1:0] shadow_q, shadow_d;
    logic [PayW-1:0] active_q, active_d;
    logic            pending_q, pending_d;
    logic            consume;

    // Frame sequencer
    state_e          state_q, state_d;
    logic [BitCw-1:0] bit_q, bit_d;
    logic [ChCw-1:0] ch_q, ch_d;

    // Registered outputs
    logic            dout_q, dout_d;
    logic            valid_q, valid_d;
    logic            start_q, start_d;
    logic            lost_q, lost_d;

    // Bit selection helpers
    logic [BitCw-1:0]  sidx, fidx;
    logic [SYNC_W-1:0] sync_shift;
    logic [PayW-1:0]   word_shift, field_shift;

    // fill_q marks when sync2_q holds a real sample rather than its reset value. The
    // detector only arms after save_data has been seen low, so a level held high through
    // reset release is not taken as a request.
    assign armed_d   = armed_q | (fill_q[1] & ~sync2_q);
    assign save_rise = sync2_q & ~edge_q & armed_q;

    // The frame register is reloaded at IDLE exit or at the end of PARITY when a
    // snapshot is waiting; CONTINUOUS only matters when nothing is pending.
    assign consume = pending_q & ((state_q == StIdle) | (state_q == StParity));

    always_comb begin
        shadow_d = save_rise ? bus.err_counts : shadow_q;
        active_d = consume ? shadow_q : active_q;
        // A load coinciding with consumption keeps pending set for the new value.
        if (save_rise) begin
            pending_d = 1'b1;
        end else if (consume) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end
        lost_d = save_rise & pending_q & ~consume;
    end

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        ch_d    = ch_q;
        case (state_q)
            StIdle: begin
                if (pending_q) begin
                    state_d = StSync;
                    bit_d   = '0;
                end
            end
            StSync: begin
                if (bit_q == SyncLast) begin
                    state_d = StData;
                    bit_d   = '0;
                    ch_d    = '0;
                end else begin
                    bit_d = bit_q + BitCw'(1);
                end
            end
            StData: begin
                if (bit_q == CntLast) begin
                    bit_d = '0;
                    if (ch_q == ChLast) begin
                        state_d = StParity;
                    end else begin
                        ch_d = ch_q + ChCw'(1);
                    end
                end else begin
                    bit_d = bit_q + BitCw'(1);
                end
            end
            StParity: begin
                if (pending_q || CONTINUOUS) begin
                    state_d = StSync;
                    bit_d   = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered, so they are decoded from the next bit position. The active
    // register is only updated on SYNC entry, so active_q is already current in DATA.
    always_comb begin
        sidx        = MSB_FIRST ? (SyncLast - bit_d) : bit_d;
        fidx        = MSB_FIRST ? (CntLast - bit_d) : bit_d;
        sync_shift  = SYNC_PAT >> sidx;
        word_shift  = active_q >> (32'(ch_d) * CNT_W);
        field_shift = word_shift >> fidx;

        dout_d  = 1'b0;
        case (state_d)
            StSync:   dout_d = sync_shift[0];
            StData:   dout_d = field_shift[0];
            StParity: dout_d = ^active_q;
            default:  dout_d = 1'b0;
        endcase
        valid_d = (state_d != StIdle);
        start_d = (state_d == StSync) && (bit_d == '0);
    end

    always_ff @(posedge data_clk or negedge reset) begin
        if (!reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            edge_q    <= 1'b0;
            fill_q    <= 2'b00;
            armed_q   <= 1'b0;
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
            state_q   <= StIdle;
            bit_q     <= '0;
            ch_q      <= '0;
            dout_q    <= 1'b0;
            valid_q   <= 1'b0;
            start_q   <= 1'b0;
            lost_q    <= 1'b0;
        end else begin
            sync1_q   <= bus.save_data;
            sync2_q   <= sync1_q;
            edge_q    <= sync2_q;
            fill_q    <= {fill_q[0], 1'b1};
            armed_q   <= armed_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            state_q   <= state_d;
            bit_q     <= bit_d;
            ch_q      <= ch_d;
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            start_q   <= start_d;
            lost_q    <= lost_d;
        end
    end

    assign bus.DATA_OUT    = dout_q;
    assign bus.frame_valid = valid_q;
    assign bus.frame_start = start_q;
    assign bus.snap_lost   = lost_q;

endmodule
